// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per cycle, LSB first, through one full-subtractor cell.
// Optional signed-overflow output ovf is built when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             busy,
    output logic             done
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
`ifdef SERIAL_SUB_OVF_EN
    logic             r_a_msb;
    logic             r_b_msb;
`endif

    logic w_ai;
    logic w_bi;
    logic w_diff;
    logic w_br_next;

    // Full-subtractor cell on the current LSBs of the shifting operand registers
    assign w_ai      = r_a[0];
    assign w_bi      = r_b[0];
    assign w_diff    = w_ai ^ w_bi ^ r_br;
    assign w_br_next = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);

    // Control FSM, serial datapath and registered result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= {WIDTH{1'b0}};
            r_b     <= {WIDTH{1'b0}};
            r_res   <= {WIDTH{1'b0}};
            r_br    <= 1'b0;
            r_cnt   <= {CW{1'b0}};
            d       <= {WIDTH{1'b0}};
            bout    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            ovf     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_br    <= bin;
                        r_res   <= {WIDTH{1'b0}};
                        r_cnt   <= {CW{1'b0}};
`ifdef SERIAL_SUB_OVF_EN
                        r_a_msb <= a[WIDTH-1];
                        r_b_msb <= b[WIDTH-1];
`endif
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    // start and the operand inputs are deliberately not looked at here
                    r_a   <= {1'b0, r_a[WIDTH-1:1]};
                    r_b   <= {1'b0, r_b[WIDTH-1:1]};
                    r_br  <= w_br_next;
                    r_res <= {w_diff, r_res[WIDTH-1:1]};
                    if (r_cnt == LAST_BIT) begin
                        d       <= {w_diff, r_res[WIDTH-1:1]};
                        bout    <= w_br_next;
`ifdef SERIAL_SUB_OVF_EN
                        ovf     <= (r_a_msb != r_b_msb) && (w_diff != r_a_msb);
`endif
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt   <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=4) with a result scoreboard popped on every done pulse.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic         bin   = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic [W-1:0] d;
    logic         bout;
    logic         busy;
    logic         done;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    typedef struct packed {
        logic [W-1:0] d;
        logic         bout;
        logic         ovf;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    int           n_cmp  = 0;
    int           n_fail = 0;
    int           n_done = 0;
    int           nd0;
    logic [W-1:0] last_d    = '0;
    logic         last_bout = 1'b0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .d     (d),
        .bout  (bout),
        .busy  (busy),
        .done  (done)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin);
        logic [W:0] t;
        exp_t       e;
        t      = {1'b0, ta} - {1'b0, tb} - {{W{1'b0}}, tbin};
        e.d    = t[W-1:0];
        e.bout = t[W];
        e.ovf  = (ta[W-1] != tb[W-1]) && (e.d[W-1] != ta[W-1]);
        return e;
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (done === 1'b1) begin
            n_done++;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("d", 32'(d), 32'(mon_e.d));
                check("bout", 32'(bout), 32'(mon_e.bout));
`ifdef SERIAL_SUB_OVF_EN
                check("ovf", 32'(ovf), 32'(mon_e.ovf));
`endif
                last_d    = mon_e.d;
                last_bout = mon_e.bout;
            end
        end
    end

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin, input string tag);
        @(posedge clk); #1;
        a = ta; b = tb; bin = tbin; start = 1'b1;
        sb.push_back(model(ta, tb, tbin));
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_nodone"}, 32'(done), 32'd0);
            check({tag, "_dhold"}, 32'(d), 32'(last_d));
            check({tag, "_bhold"}, 32'(bout), 32'(last_bout));
            @(posedge clk);
        end
        @(negedge clk);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_done_1cyc"}, 32'(done), 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_d", 32'(d), 32'd0);
        check("rst_bout", 32'(bout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;

        run_op(4'd9, 4'd3, 1'b0, "sub_9_3");
        run_op(4'd3, 4'd9, 1'b0, "sub_3_9");
        run_op(4'd8, 4'd1, 1'b0, "sub_8_1");
        run_op(4'd0, 4'd0, 1'b1, "wrap");
        run_op(4'd5, 4'd5, 1'b0, "equal");

        // Start and operand changes during RUN are ignored
        nd0 = n_done;
        @(posedge clk); #1;
        a = 4'd9; b = 4'd3; bin = 1'b0; start = 1'b1;
        sb.push_back(model(4'd9, 4'd3, 1'b0));
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; a = 4'd1; b = 4'd2;
        @(negedge clk);
        check("midrun_busy", 32'(busy), 32'd1);
        check("midrun_dhold", 32'(d), 32'(last_d));
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("midrun_dhold2", 32'(d), 32'(last_d));
        repeat (5) @(posedge clk);
        #1;
        check("midrun_single_done", 32'(n_done - nd0), 32'd1);
        check("midrun_sb_empty", 32'(sb.size()), 32'd0);

        // Reset during the second RUN cycle aborts without done
        @(posedge clk); #1;
        a = 4'd9; b = 4'd3; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_d", 32'(d), 32'd0);
        check("abort_bout", 32'(bout), 32'd0);
        rst = 1'b0;
        last_d = '0;
        last_bout = 1'b0;
        nd0 = n_done;
        repeat (6) @(posedge clk);
        #1;
        check("abort_no_done", 32'(n_done - nd0), 32'd0);
        run_op(4'd7, 4'd2, 1'b0, "after_rst");

        // start held high for 12 cycles: back-to-back operations every WIDTH+1 cycles
        nd0 = n_done;
        @(posedge clk); #1;
        a = 4'd6; b = 4'd1; bin = 1'b0; start = 1'b1;
        repeat (3) sb.push_back(model(4'd6, 4'd1, 1'b0));
        for (int j = 0; j < 18; j++) begin
            @(posedge clk); #1;
            if (j == 11) start = 1'b0;
            @(negedge clk);
            check($sformatf("hold_done_%0d", j), 32'(done), 32'((j == 4) || (j == 9) || (j == 14)));
        end
        check("hold_done_count", 32'(n_done - nd0), 32'd3);
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
